ps2_rx_controller: RTL and testbench

- Receive-side controller for the PS/2 keyboard interface.
- Synchronizes and deglitches the PS/2 clock/data pins, then sequences frame reception: start bit, 8 data bits LSB first, odd parity, stop bit.
- Delivers each good scan code through a one-entry valid/ready output buffer.
- Sits between the PS/2 pins and the scan-code decode logic; flags parity, framing and overrun errors.

---
 rtl/ps2_rx_controller.sv | 127 ++++++++++++
 tb/tb_ps2_rx_controller.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_controller.sv
// ps2_rx_controller: PS/2 receive path with pin sync, clock deglitch, frame FSM and one-entry code buffer.
module ps2_rx_controller #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_en,
  output logic [7:0] code,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;

  logic [1:0]    clk_s_q, dat_s_q;
  logic          fclk_q, fclk_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [1:0]    state_q, state_d;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    code_q, code_d;
  logic          code_valid_q, code_valid_d;
  logic          perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic          strobe, din, timeout, load;

  always_comb begin
    fcnt_d = '0;
    fclk_d = fclk_q;
    if (clk_s_q[1] != fclk_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) fclk_d = ~fclk_q;
      else fcnt_d = fcnt_q + 1'b1;
    end
    strobe    = fclk_q & ~fclk_d;
    din       = dat_s_q[1];
    state_d   = state_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    load      = 1'b0;
    tmo_d     = (state_q == IDLE || strobe) ? '0 : tmo_q + 1'b1;
    timeout   = state_q != IDLE && !strobe && tmo_q == TW'(TIMEOUT_CYCLES - 1);
    if (timeout) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
      tmo_d   = '0;
    end else if (strobe) begin
      case (state_q)
        IDLE: if (!din && rx_en) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
        DATA: begin
          sh_d[bit_cnt_q] = din;
          bit_cnt_d       = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = din;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          if (!din) ferr_d = 1'b1;
          else if (!(^{sh_q, par_q})) perr_d = 1'b1;
          else if (!code_valid_q || code_ready) load = 1'b1;
          else ovr_d = 1'b1;
        end
      endcase
    end
    code_d       = load ? sh_q : code_q;
    code_valid_d = load | (code_valid_q & ~code_ready);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s_q      <= 2'b11;
      dat_s_q      <= 2'b11;
      fclk_q       <= 1'b1;
      fcnt_q       <= '0;
      state_q      <= IDLE;
      sh_q         <= '0;
      bit_cnt_q    <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      clk_s_q      <= {clk_s_q[0], ps2_clk};
      dat_s_q      <= {dat_s_q[0], ps2_data};
      fclk_q       <= fclk_d;
      fcnt_q       <= fcnt_d;
      state_q      <= state_d;
      sh_q         <= sh_d;
      bit_cnt_q    <= bit_cnt_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      ovr_q        <= ovr_d;
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_ps2_rx_controller.sv
// tb_ps2_rx_controller: drives PS/2 frames and scoreboards delivered scan codes and error pulses.
module tb_ps2_rx_controller;
  localparam int FL = 8, TO = 300, H = 20;
  logic clk = 0, reset_n = 0, ps2_clk = 1, ps2_data = 1, rx_en = 1, code_ready = 1;
  logic [7:0] code;
  logic code_valid, parity_err, frame_err, overrun, busy;
  int n_tests = 0, n_fail = 0, cyc = 0;
  int n_rx = 0, n_cv = 0, n_perr = 0, n_ferr = 0, n_ovr = 0, t_ferr = 0, t_fall = 0;
  logic [7:0] q[$];
  logic [7:0] prev_code = 0, exp_code;
  logic prev_hold = 0;
  logic [2:0] prev_p = 0;

  ps2_rx_controller #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rx_en(rx_en),
    .code(code), .code_valid(code_valid), .code_ready(code_ready), .parity_err(parity_err),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (prev_hold) chk("hold", code, prev_code);
    prev_hold = code_valid && !code_ready;
    prev_code = code;
    if (code_valid) n_cv++;
    if (code_valid && code_ready) begin
      exp_code = q.size() != 0 ? q.pop_front() : ~code;
      chk("code", code, exp_code);
      n_rx++;
    end
    if (parity_err) n_perr++;
    if (overrun) n_ovr++;
    if (frame_err) begin
      n_ferr++;
      t_ferr = cyc;
    end
    if (parity_err | frame_err | overrun) chk("excl", $countones({parity_err, frame_err, overrun}), 1);
    if (|({parity_err, frame_err, overrun} & prev_p)) chk("pulse_w", {parity_err, frame_err, overrun} & prev_p, 0);
    prev_p = {parity_err, frame_err, overrun};
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par = 0, input bit bad_stop = 0,
                            input int nbits = 11, input int en_off_at = -1);
    logic [10:0] b;
    b = {~bad_stop, ~(^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = b[i];
      tick(H);
      ps2_clk = 0;
      t_fall = cyc;
      tick(H);
      ps2_clk = 1;
      if (i == en_off_at) rx_en = 0;
    end
    ps2_data = 1;
    tick(2 * H);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
    chk(tag, q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx0, cv0, p0, f0, o0, gap;
    tick(3);
    chk("rst_out", {code, code_valid, parity_err, frame_err, overrun, busy}, 0);
    reset_n = 1;
    tick(5);
    // good frame, immediate acceptance
    rx0 = n_rx; cv0 = n_cv; p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
    q.push_back(8'h1C);
    send_frame(8'h1C);
    tick(20);
    chk("t1_cv_cycles", n_cv - cv0, 1);
    chk("t1_rx", n_rx - rx0, 1);
    chk("t1_err", (n_perr - p0) + (n_ferr - f0) + (n_ovr - o0), 0);
    chk("t1_busy", busy, 0);
    chk("t1_q", q.size(), 0);
    // bad parity
    p0 = n_perr; cv0 = n_cv;
    send_frame(8'h1C, 1);
    chk("t2_perr", n_perr - p0, 1);
    chk("t2_cv", n_cv - cv0, 0);
    chk("t2_code", code, 8'h1C);
    // bad stop bit
    f0 = n_ferr; rx0 = n_rx;
    send_frame(8'hF0, 0, 1);
    chk("t3_ferr", n_ferr - f0, 1);
    chk("t3_rx", n_rx - rx0, 0);
    // timeout after 4 data bits
    f0 = n_ferr;
    send_frame(8'hA5, 0, 0, 5);
    chk("t4_busy_mid", busy, 1);
    for (int i = 0; i < TO + 100 && n_ferr == f0; i++) tick(1);
    chk("t4_ferr", n_ferr - f0, 1);
    gap = t_ferr - t_fall;
    chk("t4_gap_ok", gap >= TO + 8 && gap <= TO + 12, 1);
    tick(2);
    chk("t4_busy", busy, 0);
    rx0 = n_rx;
    q.push_back(8'h5A);
    send_frame(8'h5A);
    drain("t4_drain");
    chk("t4_rx", n_rx - rx0, 1);
    // overrun with consumer stalled
    code_ready = 0; o0 = n_ovr;
    q.push_back(8'h1C);
    send_frame(8'h1C);
    send_frame(8'h32);
    chk("t5_ovr", n_ovr - o0, 1);
    chk("t5_code", code, 8'h1C);
    chk("t5_cv", code_valid, 1);
    code_ready = 1;
    tick(5);
    chk("t5_q", q.size(), 0);
    chk("t5_cv_clr", code_valid, 0);
    // short clock glitch while idle
    ps2_data = 0;
    ps2_clk = 0;
    tick(FL - 2);
    ps2_clk = 1;
    tick(20);
    chk("t6_busy", busy, 0);
    ps2_data = 1;
    tick(10);
    // receiver disabled for a whole frame
    rx_en = 0; rx0 = n_rx; p0 = n_perr; f0 = n_ferr;
    send_frame(8'h1C);
    chk("t7_rx", n_rx - rx0, 0);
    chk("t7_err", (n_perr - p0) + (n_ferr - f0), 0);
    chk("t7_busy", busy, 0);
    rx_en = 1;
    // rx_en dropped mid-frame
    rx0 = n_rx;
    q.push_back(8'h29);
    send_frame(8'h29, 0, 0, 11, 3);
    chk("t8_en", rx_en, 0);
    rx_en = 1;
    drain("t8_drain");
    chk("t8_rx", n_rx - rx0, 1);
    // reset mid-DATA
    send_frame(8'h77, 0, 0, 4);
    chk("t9_busy_mid", busy, 1);
    reset_n = 0;
    #2;
    chk("t9_rst_out", {code, code_valid, parity_err, frame_err, overrun, busy}, 0);
    tick(2);
    reset_n = 1;
    tick(5);
    f0 = n_ferr; rx0 = n_rx;
    q.push_back(8'h45);
    send_frame(8'h45);
    drain("t9_drain");
    chk("t9_rx", n_rx - rx0, 1);
    chk("t9_code", code, 8'h45);
    chk("t9_ferr", n_ferr - f0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
